keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving columns and sampling rows.
- Debounces presses and releases.
- Emits one key code per press as a single-cycle strobe.
- Sits directly upstream of the keypad input/number-entry stage, which accumulates digits into the operand.

---
 rtl/keypad_if.sv | 10 +
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix lines (row/col) and key event outputs of keypad_scanner
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input row, output col, key_code, key_valid, key_held);
    modport slave (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and one-cycle key strobe; define KEYPAD_REPEAT_EN for auto-repeat while held
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input logic      clk,
    input logic      reset,
    keypad_if.master kp
);
    localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
    logic [3:0] row_meta, row_sync, row_lat, code_lat, code, col, col_next, key_code;
    logic [DW-1:0] div;
    logic [CW-1:0] deb, rel;
    logic [1:0] state, ridx, cidx;
    logic tick, single, key_valid, key_held;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [RW-1:0] rep;
    logic rep_phase;
`endif
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: parameter below its minimum");
    end
    // two-flop synchronizer for the asynchronous, pulled-up row lines
    always_ff @(posedge clk) begin
        row_meta <= reset ? 4'hF : kp.row;
        row_sync <= reset ? 4'hF : row_meta;
    end
    // sample tick, single-row detection and key lookup for the driven column
    always_comb begin
        tick     = div == DW'(SCAN_DIV - 1);
        single   = row_sync == 4'b1110 || row_sync == 4'b1101 || row_sync == 4'b1011 || row_sync == 4'b0111;
        ridx     = !row_sync[0] ? 2'd0 : !row_sync[1] ? 2'd1 : !row_sync[2] ? 2'd2 : 2'd3;
        cidx     = !col[0] ? 2'd0 : !col[1] ? 2'd1 : !col[2] ? 2'd2 : 2'd3;
        code     = KEY_MAP[{ridx, cidx, 2'b00} +: 4];
        col_next = {col[2:0], col[3]};
    end
    // dwell counter plus scan/debounce/held state machine, acting once per sample tick
    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            state     <= SCAN;
            col       <= 4'b1110;
            deb       <= '0;
            rel       <= '0;
            row_lat   <= '0;
            code_lat  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
            rep_phase <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            div       <= tick ? '0 : div + 1'b1;
`ifdef KEYPAD_REPEAT_EN
            if (state != PRESSED) begin
                rep       <= '0;
                rep_phase <= 1'b0;
            end
`endif
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single) begin
                            row_lat  <= row_sync;
                            code_lat <= code;
                            if (DEBOUNCE_CNT == 1) begin
                                key_valid <= 1'b1;
                                key_code  <= code;
                                key_held  <= 1'b1;
                                rel       <= '0;
                                state     <= PRESSED;
                            end else begin
                                deb   <= CW'(1);
                                state <= DEBOUNCE;
                            end
                        end else col <= col_next;
                    end
                    DEBOUNCE: begin
                        if (row_sync == row_lat) begin
                            if (deb + 1'b1 == CW'(DEBOUNCE_CNT)) begin
                                key_valid <= 1'b1;
                                key_code  <= code_lat;
                                key_held  <= 1'b1;
                                rel       <= '0;
                                state     <= PRESSED;
                            end else deb <= deb + 1'b1;
                        end else begin
                            state <= SCAN;
                            col   <= col_next;
                        end
                    end
                    PRESSED: begin
                        if (row_sync == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
                            rep       <= '0;
                            rep_phase <= 1'b0;
`endif
                            if (rel + 1'b1 == CW'(DEBOUNCE_CNT)) begin
                                key_held <= 1'b0;
                                rel      <= '0;
                                state    <= SCAN;
                                col      <= col_next;
                            end else rel <= rel + 1'b1;
                        end else begin
                            rel <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if ((!rep_phase && rep + 1'b1 == RW'(REPEAT_DELAY)) || (rep_phase && rep + 1'b1 == RW'(REPEAT_RATE))) begin
                                key_valid <= 1'b1;
                                rep       <= '0;
                                rep_phase <= 1'b1;
                            end else rep <= rep + 1'b1;
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
    assign kp.col       = col;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized keypad presses checked against a tick-level reference model
module tb_keypad_scanner;
    localparam int SD = 4, DB = 3;
    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] pressed = '0;
    int total = 0, bad = 0, pulses = 0;
    logic prev_valid = 1'b0;
    logic [3:0] drv [$];
    int m_mode = 0, m_col = 0, m_cnt = 0, m_rel = 0, m_row = 0;
    logic [3:0] m_pend = '0, e_code = '0, e_col;
    logic e_valid = 1'b0, e_held = 1'b0;
    logic [3:0] key_map [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                   '{4'h4, 4'h5, 4'h6, 4'hB},
                                   '{4'h7, 4'h8, 4'h9, 4'hC},
                                   '{4'hE, 4'h0, 4'hF, 4'hD}};
    keypad_if kp();
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (.clk(clk), .reset(reset), .kp(kp));
    always #5 clk = ~clk;
    // physical keypad: a row reads low when a pressed key joins it to the low column
    function automatic logic [3:0] rows_for(input logic [15:0] keys, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++) if (keys[i] && !c[i % 4]) r[i / 4] = 1'b0;
        return r;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_accept();
        e_valid = 1'b1;
        e_code  = m_pend;
        e_held  = 1'b1;
        m_rel   = 0;
        m_mode  = 2;
    endtask
    // reference: drv[j] is the row seen at edge j after reset; logic uses it two edges later
    task automatic model_edge();
        int j, zeros, ri;
        logic [3:0] s;
        e_valid = 1'b0;
        if (reset) begin
            m_mode = 0; m_col = 0; m_cnt = 0; m_rel = 0;
            e_code = '0; e_held = 1'b0;
            drv.delete();
            return;
        end
        j = drv.size() - 1;
        if (j % SD != SD - 1) return;
        s = (j >= 2) ? drv[j - 2] : 4'hF;
        zeros = $countones(~s);
        ri = 0;
        for (int k = 3; k >= 0; k--) if (!s[k]) ri = k;
        if (m_mode == 0) begin
            if (zeros == 1) begin
                m_row = ri;
                m_pend = key_map[ri][m_col];
                m_cnt = 1;
                if (m_cnt == DB) model_accept(); else m_mode = 1;
            end else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
            if (zeros == 1 && ri == m_row) begin
                m_cnt++;
                if (m_cnt == DB) model_accept();
            end else begin
                m_mode = 0;
                m_col = (m_col + 1) % 4;
            end
        end else begin
            if (s == 4'hF) begin
                m_rel++;
                if (m_rel == DB) begin
                    e_held = 1'b0;
                    m_mode = 0;
                    m_col = (m_col + 1) % 4;
                end
            end else m_rel = 0;
        end
    endtask
    task automatic check_all();
        e_col = ~(4'b0001 << m_col);
        chk("col", kp.col, e_col);
        chk("code", kp.key_code, e_code);
        chk("valid", kp.key_valid, e_valid);
        chk("held", kp.key_held, e_held);
        chk("back_to_back", prev_valid & kp.key_valid, 0);
        if (kp.key_valid === 1'b1) pulses++;
        prev_valid = kp.key_valid;
    endtask
    // one clock: drive rows at the falling edge, model the rising edge, check at the next falling edge
    task automatic cyc();
        kp.row = rows_for(pressed, kp.col);
        if (!reset) drv.push_back(kp.row);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        logic [3:0] c0;
        int k;
        kp.row = 4'hF;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_col", kp.col, 4'b1110);
        chk("rst_code", kp.key_code, 0);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_held", kp.key_held, 0);
        reset = 1'b0;
        repeat (4) cyc();
        chk("t1_rotate", kp.col, 4'b1101);
        pulses = 0;
        repeat (16) cyc();
        chk("t1_no_strobe", pulses, 0);
        pressed = 16'h0020;
        pulses = 0;
        for (int i = 0; i < 100 && !kp.key_valid; i++) cyc();
        chk("t2_strobe", kp.key_valid, 1);
        chk("t2_code", kp.key_code, 4'h5);
        chk("t2_held", kp.key_held, 1);
        chk("t2_col", kp.col, 4'b1101);
        repeat (20) cyc();
        chk("t2_one_pulse", pulses, 1);
        chk("t2_frozen", kp.col, 4'b1101);
        pressed = '0;
        for (int i = 0; i < 100 && kp.key_held; i++) cyc();
        chk("t3_released", kp.key_held, 0);
        chk("t3_resume", kp.col, 4'b1011);
        pressed = 16'h4000;
        for (int i = 0; i < 100 && !kp.key_valid; i++) cyc();
        chk("t3_strobe", kp.key_valid, 1);
        chk("t3_code", kp.key_code, 4'hF);
        pressed = '0;
        for (int i = 0; i < 100 && kp.key_held; i++) cyc();
        chk("t4_released", kp.key_held, 0);
        for (int i = 0; i < 40; i++) begin
            c0 = kp.col;
            cyc();
            if (kp.col == 4'b1110 && c0 != 4'b1110) break;
        end
        chk("t4_at_col0", kp.col, 4'b1110);
        pulses = 0;
        pressed = 16'h0001;
        repeat (4) cyc();
        pressed = '0;
        repeat (4) cyc();
        chk("t4_resume", kp.col, 4'b1101);
        chk("t4_no_strobe", pulses, 0);
        chk("t4_code_kept", kp.key_code, 4'hF);
        pressed = 16'h0808;
        pulses = 0;
        repeat (40) cyc();
        chk("t5_multi_no_strobe", pulses, 0);
        chk("t5_multi_held", kp.key_held, 0);
        pressed = 16'h0002;
        for (int i = 0; i < 100 && !kp.key_valid; i++) cyc();
        chk("t5_code", kp.key_code, 4'h2);
        repeat (3) cyc();
        chk("t5_held", kp.key_held, 1);
        reset = 1'b1;
        cyc();
        chk("t5_rst_col", kp.col, 4'b1110);
        chk("t5_rst_held", kp.key_held, 0);
        chk("t5_rst_code", kp.key_code, 0);
        chk("t5_rst_valid", kp.key_valid, 0);
        reset = 1'b0;
        pressed = '0;
        cyc();
        chk("t5_after_rst_valid", kp.key_valid, 0);
        repeat (40) begin
            k = $urandom_range(0, 9);
            pressed = '0;
            if (k < 8) pressed[$urandom_range(0, 15)] = 1'b1;
            if (k == 7) pressed[$urandom_range(0, 15)] = 1'b1;
            repeat ($urandom_range(1, 40)) cyc();
            pressed = '0;
            repeat ($urandom_range(0, 24)) cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
